// File: rtl/parser_key_extract_if.sv
// Bus bundle for parser_key_extract: upstream header/lookup beat and downstream key/header result.
// Optional counter signals exist only when KEY_EXTRACT_STATS_EN is defined.
interface parser_key_extract_if #(
  parameter int unsigned HEAD_BYTES       = 64,
  parameter int unsigned KEY_FIELD_NUM    = 8,
  parameter int unsigned KEY_OFFSET_WIDTH = 5,
  parameter int unsigned HEAD_SHIFT_WIDTH = 7,
  parameter int unsigned LEN_WIDTH        = 7
) ();
  logic                                          i_valid;
  logic                                          o_ready;
  logic [HEAD_BYTES*8-1:0]                       i_head;
  logic [LEN_WIDTH-1:0]                          i_head_len;
  logic [KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_keyOffset;
  logic [HEAD_SHIFT_WIDTH-1:0]                   i_headShift;
  logic                                          o_valid;
  logic                                          i_ready;
  logic [KEY_FIELD_NUM*16-1:0]                   o_key;
  logic [KEY_FIELD_NUM-1:0]                      o_key_valid;
  logic [HEAD_BYTES*8-1:0]                       o_head;
  logic [LEN_WIDTH-1:0]                          o_head_len;
  logic                                          o_err;
`ifdef KEY_EXTRACT_STATS_EN
  logic [31:0]                                   o_pkt_cnt;
  logic [15:0]                                   o_err_cnt;
  logic                                          i_stats_clr;
`endif

  modport slave (
`ifdef KEY_EXTRACT_STATS_EN
    input  i_stats_clr,
    output o_pkt_cnt, o_err_cnt,
`endif
    input  i_valid, i_head, i_head_len, i_keyOffset, i_headShift, i_ready,
    output o_ready, o_valid, o_key, o_key_valid, o_head, o_head_len, o_err
  );

  modport master (
`ifdef KEY_EXTRACT_STATS_EN
    output i_stats_clr,
    input  o_pkt_cnt, o_err_cnt,
`endif
    output i_valid, i_head, i_head_len, i_keyOffset, i_headShift, i_ready,
    input  o_ready, o_valid, o_key, o_key_valid, o_head, o_head_len, o_err
  );
endinterface

// File: rtl/parser_key_extract.sv
// Key extraction and header strip stage: two-register valid/ready pipeline after type lookup.
// Define KEY_EXTRACT_STATS_EN to add transfer/error counters with synchronous clear.
module parser_key_extract #(
  parameter int unsigned HEAD_BYTES       = 64,
  parameter int unsigned KEY_FIELD_NUM    = 8,
  parameter int unsigned KEY_OFFSET_WIDTH = 5,
  parameter int unsigned HEAD_SHIFT_WIDTH = 7,
  parameter int unsigned LEN_WIDTH        = 7
) (
  input logic                 i_clk,
  input logic                 i_rst,
  parser_key_extract_if.slave bus
);
  localparam int unsigned HW    = HEAD_BYTES * 8;
  localparam int unsigned KO_W  = KEY_OFFSET_WIDTH + 1;
  localparam int unsigned W_A   = (LEN_WIDTH > HEAD_SHIFT_WIDTH) ? LEN_WIDTH : HEAD_SHIFT_WIDTH;
  localparam int unsigned W_B   = (W_A > KEY_OFFSET_WIDTH + 2) ? W_A : KEY_OFFSET_WIDTH + 2;
  localparam int unsigned EXT_W = W_B + 1;

  logic                          s1_valid;
  logic                          s2_valid;
  logic [HW-1:0]                 s1_head;
  logic [LEN_WIDTH-1:0]          s1_len;
  logic [KEY_FIELD_NUM*KO_W-1:0] s1_off;
  logic [HEAD_SHIFT_WIDTH-1:0]   s1_shift;

  logic accept;
  logic s1_adv;

  assign bus.o_ready = ~s1_valid | ~s2_valid | bus.i_ready;
  assign bus.o_valid = s2_valid;
  assign accept      = bus.i_valid & bus.o_ready;
  assign s1_adv      = s1_valid & (~s2_valid | bus.i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_head  <= '0;
      s1_len   <= '0;
      s1_off   <= '0;
      s1_shift <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_head  <= bus.i_head;
      s1_len   <= bus.i_head_len;
      s1_off   <= bus.i_keyOffset;
      s1_shift <= bus.i_headShift;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic [KEY_FIELD_NUM*16-1:0] c_key;
  logic [KEY_FIELD_NUM-1:0]    c_kv;
  logic [HW-1:0]               c_head;
  logic [LEN_WIDTH-1:0]        c_len;
  logic                        c_err;
  logic [EXT_W-1:0]            len_ext;
  logic [EXT_W-1:0]            shift_ext;
  logic [EXT_W-1:0]            addr_end;
  logic [KEY_OFFSET_WIDTH:0]   baddr;
  logic [HW-1:0]               key_win;

  // Byte 0 sits in the MSBs, so a left shift by N bytes brings byte N to the top
  // and zero-fills past the window end for both key fetch and header strip.
  always_comb begin
    c_key     = '0;
    c_kv      = '0;
    key_win   = '0;
    baddr     = '0;
    addr_end  = '0;
    len_ext   = EXT_W'(s1_len);
    shift_ext = EXT_W'(s1_shift);
    for (int unsigned j = 0; j < KEY_FIELD_NUM; j++) begin
      baddr    = {s1_off[j*KO_W +: KEY_OFFSET_WIDTH], 1'b0};
      addr_end = EXT_W'(baddr) + EXT_W'(2);
      key_win  = s1_head << {baddr, 3'b000};
      if (s1_off[j*KO_W + KEY_OFFSET_WIDTH] && (addr_end <= len_ext)) begin
        c_kv[j]            = 1'b1;
        c_key[j*16 +: 16]  = key_win[HW-1 -: 16];
      end
    end
    c_head = s1_head << {s1_shift, 3'b000};
    if (shift_ext <= len_ext) begin
      c_len = LEN_WIDTH'(len_ext - shift_ext);
      c_err = 1'b0;
    end else begin
      c_len = '0;
      c_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid        <= 1'b0;
      bus.o_key       <= '0;
      bus.o_key_valid <= '0;
      bus.o_head      <= '0;
      bus.o_head_len  <= '0;
      bus.o_err       <= 1'b0;
    end else if (s1_adv) begin
      s2_valid        <= 1'b1;
      bus.o_key       <= c_key;
      bus.o_key_valid <= c_kv;
      bus.o_head      <= c_head;
      bus.o_head_len  <= c_len;
      bus.o_err       <= c_err;
    end else if (bus.i_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef KEY_EXTRACT_STATS_EN
  logic xfer;
  assign xfer = s2_valid & bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_pkt_cnt <= '0;
      bus.o_err_cnt <= '0;
    end else if (bus.i_stats_clr) begin
      bus.o_pkt_cnt <= '0;
      bus.o_err_cnt <= '0;
    end else if (xfer) begin
      bus.o_pkt_cnt <= bus.o_pkt_cnt + 32'd1;
      if (bus.o_err && (bus.o_err_cnt != '1))
        bus.o_err_cnt <= bus.o_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_parser_key_extract.sv
// Scoreboard bench for parser_key_extract: byte-level reference model, directed and random traffic.
module tb_parser_key_extract;
  localparam int unsigned HB   = 64;
  localparam int unsigned KFN  = 8;
  localparam int unsigned KOW  = 5;
  localparam int unsigned HSW  = 7;
  localparam int unsigned LW   = 7;
  localparam int unsigned KO_W = KOW + 1;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  parser_key_extract_if #(
    .HEAD_BYTES(HB), .KEY_FIELD_NUM(KFN), .KEY_OFFSET_WIDTH(KOW),
    .HEAD_SHIFT_WIDTH(HSW), .LEN_WIDTH(LW)
  ) bus ();

  parser_key_extract #(
    .HEAD_BYTES(HB), .KEY_FIELD_NUM(KFN), .KEY_OFFSET_WIDTH(KOW),
    .HEAD_SHIFT_WIDTH(HSW), .LEN_WIDTH(LW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  typedef struct {
    logic [HB*8-1:0]     head;
    logic [LW-1:0]       len;
    logic [KFN*KO_W-1:0] ko;
    logic [HSW-1:0]      sh;
  } txn_t;

  typedef struct {
    logic [KFN*16-1:0] key;
    logic [KFN-1:0]    kv;
    logic [HB*8-1:0]   head;
    logic [LW-1:0]     len;
    logic              err;
    int                acc_cyc;
    bit                chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  bit   rdy_low = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   lat_ok  = 1'b1;
  int   exp_pkt = 0;
  int   exp_errc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Reference: treat the header as a byte array and apply the extraction rules directly.
  function automatic exp_t model(input txn_t t);
    exp_t        m;
    byte unsigned hb[HB];
    byte unsigned ob[HB];
    int unsigned off, b, s, l;
    byte unsigned hi, lo;
    m.key = '0; m.kv = '0; m.head = '0; m.acc_cyc = 0; m.chk_lat = 1'b0;
    for (int unsigned k = 0; k < HB; k++) hb[k] = t.head[(HB-1-k)*8 +: 8];
    l = t.len;
    s = t.sh;
    for (int unsigned j = 0; j < KFN; j++) begin
      off = t.ko[j*KO_W +: KOW];
      b   = 2 * off;
      hi  = (b < HB) ? hb[b] : 8'h00;
      lo  = (b + 1 < HB) ? hb[b+1] : 8'h00;
      if (t.ko[j*KO_W + KOW] && (b + 2 <= l)) begin
        m.kv[j] = 1'b1;
        m.key[j*16 +: 16] = {hi, lo};
      end
    end
    for (int unsigned k = 0; k < HB; k++) begin
      ob[k] = (k + s < HB) ? hb[k+s] : 8'h00;
      m.head[(HB-1-k)*8 +: 8] = ob[k];
    end
    if (s <= l) begin
      m.len = LW'(l - s);
      m.err = 1'b0;
    end else begin
      m.len = '0;
      m.err = 1'b1;
    end
    return m;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    int unsigned l, s;
    for (int unsigned w = 0; w < HB/4; w++) t.head[w*32 +: 32] = $urandom();
    l = $urandom_range(0, HB);
    if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 127);
    else s = $urandom_range(0, l);
    t.len = LW'(l);
    t.sh  = HSW'(s);
    t.ko  = (KFN*KO_W)'({$urandom(), $urandom()});
    return t;
  endfunction

  function automatic txn_t inc_txn(input int unsigned l, input int unsigned s);
    txn_t t;
    for (int unsigned k = 0; k < HB; k++) t.head[(HB-1-k)*8 +: 8] = 8'(k);
    t.len = LW'(l);
    t.sh  = HSW'(s);
    t.ko  = '0;
    return t;
  endfunction

  task automatic send(input txn_t t, output bit first);
    exp_t e;
    int   n = 0;
    @(negedge i_clk);
    bus.i_valid     = 1'b1;
    bus.i_head      = t.head;
    bus.i_head_len  = t.len;
    bus.i_keyOffset = t.ko;
    bus.i_headShift = t.sh;
    #1;
    first = bus.o_ready;
    while (!bus.o_ready && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: o_ready stuck at 0 required 1");
    end else begin
      e = model(t);
      e.acc_cyc = cyc + 1;
      e.chk_lat = lat_ok;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d required 0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  initial begin : ready_drv
    bus.i_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      bus.i_ready = rdy_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst) continue;
      if (bus.o_valid && !bus.i_ready && exp_q.size() != 0) begin
        chk("stall_key", 512'(bus.o_key), 512'(exp_q[0].key));
        chk("stall_head", 512'(bus.o_head), 512'(exp_q[0].head));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: o_valid 1 with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          chk("key", 512'(bus.o_key), 512'(e.key));
          chk("key_valid", 512'(bus.o_key_valid), 512'(e.kv));
          chk("head", 512'(bus.o_head), 512'(e.head));
          chk("head_len", 512'(bus.o_head_len), 512'(e.len));
          chk("err", 512'(bus.o_err), 512'(e.err));
          if (e.chk_lat) chk("latency", 512'(cyc + 1 - e.acc_cyc), 512'(2));
          exp_pkt++;
          if (e.err && exp_errc < 65535) exp_errc++;
        end
      end
    end
  end

  initial begin : stim
    txn_t t;
    bit   first;
    i_rst           = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_head      = '0;
    bus.i_head_len  = '0;
    bus.i_keyOffset = '0;
    bus.i_headShift = '0;
`ifdef KEY_EXTRACT_STATS_EN
    bus.i_stats_clr = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_o_valid", 512'(bus.o_valid), 512'(0));
    chk("rst_o_ready", 512'(bus.o_ready), 512'(1));
    chk("rst_o_key", 512'(bus.o_key), 512'(0));
    chk("rst_o_key_valid", 512'(bus.o_key_valid), 512'(0));
    chk("rst_o_head", 512'(bus.o_head), 512'(0));
    chk("rst_o_head_len", 512'(bus.o_head_len), 512'(0));
    chk("rst_o_err", 512'(bus.o_err), 512'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // Basic extraction, length limit, shift overflow.
    t = inc_txn(64, 14);
    t.ko[0*KO_W +: KO_W] = {1'b1, 5'd6};
    t.ko[1*KO_W +: KO_W] = {1'b1, 5'd31};
    send(t, first);
    t = inc_txn(20, 0);
    t.ko[0*KO_W +: KO_W] = {1'b1, 5'd9};
    t.ko[1*KO_W +: KO_W] = {1'b1, 5'd10};
    send(t, first);
    t = inc_txn(10, 12);
    t.ko[0*KO_W +: KO_W] = {1'b1, 5'd3};
    t.ko[3*KO_W +: KO_W] = {1'b1, 5'd4};
    send(t, first);
    t = inc_txn(64, 64);
    t.ko[7*KO_W +: KO_W] = {1'b1, 5'd31};
    send(t, first);
    idle();
    drain();

    // Backpressure: stall the output after two accepts.
    lat_ok = 1'b0;
    send(rnd_txn(), first);
    send(rnd_txn(), first);
    rdy_low = 1'b1;
    fork
      begin
        send(rnd_txn(), first);
        chk("bp_blocked", 512'(first), 512'(0));
        send(rnd_txn(), first);
      end
      begin
        repeat (6) @(negedge i_clk);
        rdy_low = 1'b0;
      end
    join
    idle();
    drain();

    // Full throughput.
    lat_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(rnd_txn(), first);
      chk("tput_accept", 512'(first), 512'(1));
    end
    idle();
    drain();

    // Random traffic with random downstream stalls.
    lat_ok   = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(rnd_txn(), first);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rand_rdy = 1'b0;
    drain();

    // Reset with both stages full.
    rdy_low = 1'b1;
    send(rnd_txn(), first);
    send(rnd_txn(), first);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    #1;
    chk("full_o_ready", 512'(bus.o_ready), 512'(0));
    #3;
    i_rst = 1'b1;
    #1;
    chk("midrst_o_valid", 512'(bus.o_valid), 512'(0));
    chk("midrst_o_ready", 512'(bus.o_ready), 512'(1));
    chk("midrst_o_key", 512'(bus.o_key), 512'(0));
    chk("midrst_o_head_len", 512'(bus.o_head_len), 512'(0));
    exp_q.delete();
    exp_pkt  = 0;
    exp_errc = 0;
    rdy_low  = 1'b0;
    @(negedge i_clk);
    i_rst  = 1'b0;
    lat_ok = 1'b1;
    send(rnd_txn(), first);
    chk("post_rst_accept", 512'(first), 512'(1));
    idle();
    drain();

`ifdef KEY_EXTRACT_STATS_EN
    t = inc_txn(10, 12);
    send(t, first);
    idle();
    drain();
    chk("pkt_cnt", 512'(bus.o_pkt_cnt), 512'(exp_pkt));
    chk("err_cnt", 512'(bus.o_err_cnt), 512'(exp_errc));
    @(negedge i_clk);
    bus.i_stats_clr = 1'b1;
    @(negedge i_clk);
    bus.i_stats_clr = 1'b0;
    #1;
    chk("pkt_cnt_clr", 512'(bus.o_pkt_cnt), 512'(0));
    chk("err_cnt_clr", 512'(bus.o_err_cnt), 512'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/parser_key_extract.md
Name: parser_key_extract

Overview:
- Downstream neighbour of the type-lookup stage in the pipelined parser.
- Accepts one header beat per transaction, together with the key offsets and head shift produced by the lookup for that header.
- Extracts KEY_FIELD_NUM 16-bit key fields, strips the parsed header (left shift by head-shift bytes), and presents the results to the next parser layer.
- Two-register pipeline with valid/ready handshake and full-throughput backpressure.

Parameters:
- HEAD_BYTES, 64: header window width in bytes; byte 0 is at bits [HEAD_BYTES*8-1 -: 8].
- KEY_FIELD_NUM, 8: number of key fields per transaction.
- KEY_OFFSET_WIDTH, 5: key offset width, in 2-byte units; each offset port carries 1 extra valid bit at the top.
- HEAD_SHIFT_WIDTH, 7: width of the head shift in bytes.
- LEN_WIDTH, 7: width of the header length in bytes (0..HEAD_BYTES).

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_valid, input, 1: input transaction valid.
- o_ready, output, 1: stage can accept a transaction.
- i_head, input, HEAD_BYTES*8: header window.
- i_head_len, input, LEN_WIDTH: valid bytes in i_head.
- i_keyOffset, input, KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1): per field {valid, offset}; field j occupies slice j.
- i_headShift, input, HEAD_SHIFT_WIDTH: bytes to strip.
- o_valid, output, 1: output valid.
- i_ready, input, 1: downstream ready.
- o_key, output, KEY_FIELD_NUM*16: extracted key fields; field j at [j*16+:16].
- o_key_valid, output, KEY_FIELD_NUM: per-field valid.
- o_head, output, HEAD_BYTES*8: shifted header.
- o_head_len, output, LEN_WIDTH: remaining length.
- o_err, output, 1: shift exceeded length.

Behaviour:
- Reset: asynchronous on i_rst high. Both stage-valid flags clear, so o_valid=0 and o_ready=1. o_key, o_key_valid, o_head, o_head_len and o_err all reset to 0.
- Reset mid-operation discards both in-flight transactions. No output is produced for them.
- Stage S1 captures i_head, i_head_len, i_keyOffset and i_headShift when i_valid & o_ready.
- Stage S2 captures the computed results from S1 when S1 is valid and S2 is free or draining.
- Handshake:
  - o_ready = ~s1_valid | ~s2_valid | i_ready. This is combinational from i_ready; no skid buffer is used.
  - An output transfer occurs on o_valid & i_ready.
  - Output fields hold stable while o_valid & ~i_ready.
  - s2_valid clears on transfer unless S1 advances in the same cycle.
- Simultaneous accept, advance and transfer in one cycle is legal and sustains 1 transaction/cycle.
- Latency: 2 cycles from input accept to o_valid, with no backpressure.
- Key extraction, per field j, with off = offset bits:
  - Byte address b = 2*off.
  - o_key[j] = {byte b, byte b+1}. A byte index >= HEAD_BYTES reads 0.
  - o_key_valid[j] = valid bit & (b+2 <= head_len); otherwise o_key[j] is forced to 0.
- Header shift, with s = headShift:
  - Output byte k = input byte k+s, zero-filled.
  - s >= HEAD_BYTES yields an all-zero o_head.
- Length and error:
  - If s <= head_len: o_head_len = head_len - s and o_err = 0.
  - Otherwise o_head_len = 0, o_err = 1, and o_key_valid is still computed normally.
- Arithmetic is unsigned. Width extension is to max(LEN_WIDTH, HEAD_SHIFT_WIDTH)+1, so the comparisons never wrap.
- Order preserved; no drops; no reordering.

Optional Feature:
- Macro KEY_EXTRACT_STATS_EN adds the following ports, each cleared by i_rst:
  - o_pkt_cnt, 32-bit: increments on every output transfer.
  - o_err_cnt, 16-bit: increments on output transfers with o_err=1; saturates at 16'hFFFF.
  - i_stats_clr, 1-bit: synchronous clear of both counters.
- When i_stats_clr coincides with a transfer, the clear wins and the counter goes to 0.
- Without the macro these ports and counters do not exist. Datapath and timing are identical in both builds.

Test Plan:
- Basic extraction:
  - Stimulus: i_head bytes = 0x00,0x01,...,0x3F; len=64; field0={1,off=6}; field1={1,off=31}; other fields invalid; shift=14.
  - Response: 2 cycles later o_key[0]=16'h0C0D, o_key[1]=16'h3E3F, o_key_valid=8'h03, o_head byte0=0x0E, byte49=0x3F, bytes50..63=0, o_head_len=50, o_err=0.
- Length limit:
  - Stimulus: len=20; field0 off=9; field1 off=10.
  - Response: o_key_valid[0]=1 (bytes 18,19); o_key_valid[1]=0 with o_key[1]=0.
- Shift overflow:
  - Stimulus: len=10; shift=12.
  - Response: o_err=1, o_head_len=0; bytes 0..51 of o_head = input bytes 12..63, bytes 52..63 = 0. With the stats macro, o_err_cnt=1.
- Backpressure:
  - Stimulus: send 4 back-to-back transactions with i_ready held low for cycles 2..6.
  - Response: o_ready deasserts once both stages are full; outputs hold stable while stalled; all 4 transactions emerge in order; o_pkt_cnt=4.
- Throughput:
  - Stimulus: 16 transactions with i_valid and i_ready continuously high.
  - Response: 16 outputs on 16 consecutive cycles, starting at cycle 2.
- Reset mid-flight:
  - Stimulus: assert i_rst asynchronously with both stages full.
  - Response: o_valid=0 and o_ready=1 immediately. After release, the next transaction appears 2 cycles after its accept.
